seq_divider: RTL

- Iterative unsigned restoring divider; one quotient bit per clock.
- Inverse companion of the team's shift-add sequential multiplier.
- Same start/busy style handshake as the multiplier.
- Sits beside the ALU as a multi-cycle functional unit for DIVU/REMU-style operations; the pipeline stalls while busy is high.

---
 rtl/div_pkg.sv | 21 ++
 rtl/seq_divider_if.sv | 29 ++
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 99 +++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared state encoding and constants for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;

    // Sliced to the instance width; all ones is the conventional x/0 quotient.
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_if
// Description : start/busy/done handshake and operand/result bus of the divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface : seq_divider_if
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step (one quotient bit).
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic             i_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic                  o_qbit
);
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;

    assign w_rem_sh = {i_rem, i_bit};
    // rem < divisor on entry, so the trial fits a signed WIDTH+1 value: MSB is the sign.
    assign w_trial  = w_rem_sh - {1'b0, i_divisor};
    assign o_qbit   = ~w_trial[WIDTH];
    assign o_rem    = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Iterative unsigned restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq_divider_if.slave bus
);
    localparam int                 CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   C_LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   C_DZ_QUO    = DIV_ZERO_QUOTIENT[WIDTH-1:0];

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH-1:0] w_step_rem;
    logic             w_qbit;
    logic [WIDTH-1:0] w_quo_next;

    // r_quo doubles as the dividend shifter: its MSB feeds the step, quotient bits enter at the LSB.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_dvsr),
        .o_rem     (w_step_rem),
        .o_qbit    (w_qbit)
    );

    assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_quotient  <= C_DZ_QUO;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_quo   <= bus.dividend;
                            r_dvsr  <= bus.divisor;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_dbz   <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST_STEP) begin
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_step_rem;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.div_by_zero = r_dbz;

endmodule : seq_divider
`default_nettype wire
